// File: rtl/axi4_ic_pkg.sv
`default_nettype none
// ============================================================================
// axi4_ic_pkg : shared types and helpers for the AXI4 interconnect arbiters
// Revision    : 1.0
// ============================================================================
package axi4_ic_pkg;

  localparam int c_axi_len_w = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  // A single-master port still needs a 1-bit index.
  function automatic int midx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_core.sv
`default_nettype none
// ============================================================================
// rr_arbiter_core : combinational round-robin pick, ptr has highest priority
// Revision        : 1.0
// ============================================================================
module rr_arbiter_core #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_pos;
  logic [IDX_W:0]   w_sum;

  // Rotate so bit 0 is the ptr position; the lowest set bit wins.
  assign w_rot = N'({req, req} >> ptr);

  always_comb begin
    w_pos = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) w_pos = IDX_W'(k);
    end
  end

  assign w_sum = {1'b0, ptr} + {1'b0, w_pos};
  assign idx   = (w_sum >= (IDX_W + 1)'(N)) ? IDX_W'(w_sum - (IDX_W + 1)'(N)) : IDX_W'(w_sum);
  assign any   = |req;

endmodule
`default_nettype wire

// File: rtl/axi4_wr_slave_arbiter.sv
`default_nettype none
// ============================================================================
// axi4_wr_slave_arbiter : per-slave AW/W round-robin arbiter with WLAST check
// Revision              : 1.0
// ============================================================================
module axi4_wr_slave_arbiter
  import axi4_ic_pkg::*;
#(
  parameter int NUM_MASTERS = 8,
  parameter int MIDX_W      = midx_w(NUM_MASTERS)
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUM_MASTERS-1:0]   m_req,
  input  logic [NUM_MASTERS*8-1:0] m_awlen,
  output logic [NUM_MASTERS-1:0]   m_awready,
  output logic                     s_awvalid,
  input  logic                     s_awready,
  input  logic [NUM_MASTERS-1:0]   m_wvalid,
  input  logic [NUM_MASTERS-1:0]   m_wlast,
  output logic [NUM_MASTERS-1:0]   m_wready,
  output logic                     s_wvalid,
  output logic                     s_wlast,
  input  logic                     s_wready,
  output logic                     grant_valid,
  output logic [MIDX_W-1:0]        grant_idx,
  output logic                     wlast_err
);

  localparam logic [MIDX_W-1:0] c_last_idx = MIDX_W'(NUM_MASTERS - 1);

  arb_state_e             r_state;
  logic [MIDX_W-1:0]      r_rr_ptr;
  logic [MIDX_W-1:0]      r_grant_idx;
  logic                   r_grant_valid;
  logic [c_axi_len_w-1:0] r_beat_cnt;
  logic [c_axi_len_w-1:0] r_len_q;
  logic                   r_wlast_err;

  logic [MIDX_W-1:0]      w_pick_idx;
  logic                   w_pick_any;
  logic                   w_aw_hs;
  logic                   w_w_hs;
  logic                   w_last_beat;

  rr_arbiter_core #(
    .N     (NUM_MASTERS),
    .IDX_W (MIDX_W)
  ) u_rr_core (
    .req (m_req),
    .ptr (r_rr_ptr),
    .idx (w_pick_idx),
    .any (w_pick_any)
  );

  assign s_awvalid   = (r_state == ADDR) & m_req[r_grant_idx];
  assign s_wvalid    = (r_state == DATA) & m_wvalid[r_grant_idx];
  assign s_wlast     = (r_state == DATA) & m_wlast[r_grant_idx];
  assign w_aw_hs     = s_awvalid & s_awready;
  assign w_w_hs      = s_wvalid & s_wready;
  assign w_last_beat = (r_beat_cnt == r_len_q);

  always_comb begin
    m_awready = '0;
    m_wready  = '0;
    if (r_state == ADDR) m_awready[r_grant_idx] = s_awready;
    if (r_state == DATA) m_wready[r_grant_idx]  = s_wready;
  end

  // The burst ends on the beat count; WLAST is only checked, never trusted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= IDLE;
      r_rr_ptr      <= '0;
      r_grant_idx   <= '0;
      r_grant_valid <= 1'b0;
      r_beat_cnt    <= '0;
      r_len_q       <= '0;
      r_wlast_err   <= 1'b0;
    end else begin
      r_wlast_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_grant_idx   <= w_pick_idx;
            r_grant_valid <= 1'b1;
            r_state       <= ADDR;
          end
        end
        ADDR: begin
          if (w_aw_hs) begin
            r_len_q    <= m_awlen[int'(r_grant_idx) * c_axi_len_w +: c_axi_len_w];
            r_beat_cnt <= '0;
            r_state    <= DATA;
          end
        end
        DATA: begin
          if (w_w_hs) begin
            r_beat_cnt  <= r_beat_cnt + c_axi_len_w'(1);
            r_wlast_err <= (s_wlast != w_last_beat);
            if (w_last_beat) begin
              r_state       <= IDLE;
              r_grant_valid <= 1'b0;
              r_rr_ptr      <= (r_grant_idx == c_last_idx) ? '0 : r_grant_idx + MIDX_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant_valid = r_grant_valid;
  assign grant_idx   = r_grant_idx;
  assign wlast_err   = r_wlast_err;

endmodule
`default_nettype wire
